// File: rtl/alu_pkg.sv
// Shared constants and op-code encoding for the registered execute-stage ALU.
package alu_pkg;

   localparam int unsigned CTRL_W        = 3;
   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef enum logic [CTRL_W-1:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b011,
      ALU_MUL = 3'b100,
      ALU_SLT = 3'b101,
      ALU_XOR = 3'b110,
      ALU_NOR = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: next result and next zero flag from a, b, ctrl.
// Multiplier is built only when ALU_MUL_EN is defined; otherwise MUL yields 0.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [WIDTH-1:0]  res_c,
   output logic              zero_c
);

   logic w_lt;

   assign w_lt = ($signed(a) < $signed(b));

   always_comb begin
      res_c = '0;
      case (alu_op_e'(ctrl))
         ALU_AND: res_c = a & b;
         ALU_OR:  res_c = a | b;
         ALU_ADD: res_c = a + b;
         ALU_SUB: res_c = a - b;
`ifdef ALU_MUL_EN
         ALU_MUL: res_c = a * b;
`else
         ALU_MUL: res_c = '0;
`endif
         ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, w_lt};
         ALU_XOR: res_c = a ^ b;
         ALU_NOR: res_c = ~(a | b);
         default: res_c = '0;
      endcase
   end

   assign zero_c = (res_c == '0);

endmodule

// File: rtl/alu_unit.sv
// Registered ALU with one cycle of latency and a valid bit alongside the data.
// Optional multiplier enabled by ALU_MUL_EN (see alu_comb).
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [WIDTH-1:0]  out,
   output logic              zero,
   output logic              out_valid
);

   logic [WIDTH-1:0] w_res;
   logic             w_zero;
   logic [WIDTH-1:0] r_out;
   logic             r_zero;
   logic             r_valid;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a      (a),
      .b      (b),
      .ctrl   (ctrl),
      .res_c  (w_res),
      .zero_c (w_zero)
   );

   // Data path loads every cycle; in_valid only qualifies the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_zero  <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         r_out   <= w_res;
         r_zero  <= w_zero;
         r_valid <= in_valid;
      end
   end

   assign out       = r_out;
   assign zero      = r_zero;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  ctrl;
   logic [31:0] out;
   logic        zero;
   logic        out_valid;

   int tests;
   int fails;

   alu_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .ctrl      (ctrl),
      .out       (out),
      .zero      (zero),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs, clock once, then check the registered outputs.
   task automatic step(input string tag, input logic v, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [2:0] ic,
                       input logic [31:0] e_out, input logic e_zero, input logic e_valid);
      in_valid = v;
      a        = ia;
      b        = ib;
      ctrl     = ic;
      @(posedge clk);
      #1;
      chk({tag, ".out"}, out, e_out);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_valid});
   endtask

   logic [31:0] mul_exp;
   logic        mul_zero;

   initial begin
      tests    = 0;
      fails    = 0;
`ifdef ALU_MUL_EN
      mul_exp  = 32'd20000;
      mul_zero = 1'b0;
`else
      mul_exp  = 32'd0;
      mul_zero = 1'b1;
`endif
      rst = 1'b1;
      step("reset0", 1'b1, 32'd200, 32'd100, 3'b010, 32'd0, 1'b1, 1'b0);
      rst = 1'b0;

      step("and", 1'b1, 32'd200, 32'd100, 3'b000, 32'd64,  1'b0, 1'b1);
      step("or",  1'b1, 32'd200, 32'd100, 3'b001, 32'd236, 1'b0, 1'b1);
      step("add", 1'b1, 32'd200, 32'd100, 3'b010, 32'd300, 1'b0, 1'b1);
      step("sub", 1'b1, 32'd200, 32'd100, 3'b011, 32'd100, 1'b0, 1'b1);
      step("mul", 1'b1, 32'd200, 32'd100, 3'b100, mul_exp, mul_zero, 1'b1);

      step("sub_eq",   1'b1, 32'd100,       32'd100, 3'b011, 32'd0, 1'b1, 1'b1);
      step("add_wrap", 1'b1, 32'hFFFF_FFFF, 32'd1,   3'b010, 32'd0, 1'b1, 1'b1);
      step("sub_wrap", 1'b1, 32'd0,         32'd1,   3'b011, 32'hFFFF_FFFF, 1'b0, 1'b1);
      step("slt_neg",  1'b1, 32'hFFFF_FFFB, 32'd3,   3'b101, 32'd1, 1'b0, 1'b1);
      step("slt_swap", 1'b1, 32'd3, 32'hFFFF_FFFB,   3'b101, 32'd0, 1'b1, 1'b1);
      step("xor_eq",   1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b110, 32'd0, 1'b1, 1'b1);
      step("nor_zero", 1'b1, 32'd0, 32'd0, 3'b111, 32'hFFFF_FFFF, 1'b0, 1'b1);
      step("xor_mix",  1'b1, 32'hF0F0_0000, 32'h0FF0_1234, 3'b110, 32'hFF00_1234, 1'b0, 1'b1);

      // Reset held two cycles with valid ADD operations pending.
      rst = 1'b1;
      step("rst_a", 1'b1, 32'd200, 32'd100, 3'b010, 32'd0, 1'b1, 1'b0);
      step("rst_b", 1'b1, 32'd200, 32'd100, 3'b010, 32'd0, 1'b1, 1'b0);
      rst = 1'b0;
      step("post_rst", 1'b1, 32'd200, 32'd100, 3'b010, 32'd300, 1'b0, 1'b1);

      step("vld_1", 1'b1, 32'd200, 32'd100, 3'b010, 32'd300, 1'b0, 1'b1);
      step("vld_0", 1'b0, 32'd200, 32'd100, 3'b010, 32'd300, 1'b0, 1'b0);
      step("vld_2", 1'b1, 32'd200, 32'd100, 3'b010, 32'd300, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered 32-bit integer ALU for the execute stage of the pipelined CPU.
- Takes two operands and a 3-bit operation select, and produces a result and a zero flag.
- Each operation is computed combinationally and captured in an output register, giving one cycle of latency.
- A valid bit travels alongside the data so downstream logic can qualify the result.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and ctrl are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ctrl  input  3  operation select.
- out  output  WIDTH  registered result.
- zero  output  1  registered flag; 1 when out is all zeros.
- out_valid  output  1  out/zero hold the result of a valid operation.

Behaviour:
- Operation encoding for ctrl, all modulo 2^WIDTH:
  - 000 AND: a & b.
  - 001 OR: a | b.
  - 010 ADD: a + b, carry discarded.
  - 011 SUB: a - b, two's complement, borrow discarded.
  - 100 MUL: low WIDTH bits of a*b; operands treated as unsigned, and the low half is sign-agnostic.
  - 101 SLT: 1 if $signed(a) < $signed(b), else 0; result zero-extended.
  - 110 XOR: a ^ b.
  - 111 NOR: ~(a | b).
- zero is derived from the same next-result value and registered together with it, so it always matches out.
- Latency: a value presented at edge N appears on out/zero at edge N+1.
- out_valid at edge N+1 equals in_valid at edge N.
- out and zero update every cycle regardless of in_valid. in_valid only drives out_valid, so no enable gating is needed on the data path.
- No overflow or carry outputs. ADD 0xFFFFFFFF+1 gives 0 with zero=1; SUB 0-1 gives 0xFFFFFFFF.
- Reset: while rst=1 at a rising edge, out=0, zero=1, out_valid=0. Reset wins over any simultaneous valid input.
- Reset mid-stream: an in-flight operation is discarded. The first post-reset result is the one sampled at the first edge where rst=0.
- ctrl is fully decoded; there are no illegal codes.
- No X propagation from out-of-range ctrl is allowed. Use a default branch that produces 0.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: ctrl=100 performs MUL as specified above, and a WIDTH x WIDTH multiplier is instantiated.
- Undefined: no multiplier is built. ctrl=100 yields out=0 and zero=1, and out_valid still follows in_valid.
- All other codes are unaffected in either build.

Decomposition:
- Package alu_pkg holds:
  - the ctrl width constant, 3;
  - named localparams/enum for the eight op codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT, ALU_XOR, ALU_NOR);
  - the default WIDTH constant.
- One natural sub-module, alu_comb: purely combinational, taking a, b, ctrl and producing the next result and next zero.
- alu_unit wraps alu_comb with the output/valid registers and the reset logic.

Test Plan:
- a=200, b=100, in_valid=1, ctrl swept 000,001,010,011,100 on consecutive edges. One cycle later each, out = 64, 236, 300, 100, 20000 (20000 only with ALU_MUL_EN; 0 without), zero=0 for all except MUL-disabled, out_valid=1.
- a=100, b=100, ctrl=011 -> out=0, zero=1. a=0xFFFFFFFF, b=1, ctrl=010 -> out=0, zero=1 (wrap-around).
- a=-5 (0xFFFFFFFB), b=3, ctrl=101 -> out=1. Swap the operands -> out=0, zero=1. ctrl=110 with a=b=0xA5A5A5A5 -> out=0. ctrl=111 with a=b=0 -> out=0xFFFFFFFF.
- Assert rst for 2 cycles while in_valid=1 and ctrl=010 -> out=0, zero=1, out_valid=0 throughout. Deassert rst -> the first result appears on the next edge.
- Toggle in_valid 1,0,1 with a=200, b=100, ctrl=010 -> out_valid follows 1,0,1 one cycle later, and out=300 every cycle.
